// File: rtl/tdma_net_pkg.sv
// Shared field layout for the Nios PIO words and TDMA packets, plus the
// presenter state type used by tdma_net_iface.
package tdma_net_pkg;

    // send_word / recv_word layout
    localparam int TOG_BIT   = 31;
    localparam int ACK_BIT   = 30;
    localparam int FULL_BIT  = 30;
    localparam int DEST_MSB  = 29;
    localparam int DEST_LSB  = 26;
    localparam int PAYLOAD_W = 26;

    // Packet layout: {dest[3:0], src[3:0], payload[25:0]}
    localparam int NODE_W = 4;
    localparam int PKT_W  = 2 * NODE_W + PAYLOAD_W;
    localparam int RX_W   = PKT_W - NODE_W;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } pres_state_e;

    function automatic logic [PKT_W-1:0] make_pkt(
        input logic [NODE_W-1:0]    dest,
        input logic [NODE_W-1:0]    src,
        input logic [PAYLOAD_W-1:0] payload
    );
        return {dest, src, payload};
    endfunction

endpackage

// File: rtl/tdma_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push and pop in the same
// cycle are both honoured. Push is ignored when full, pop when empty.
module tdma_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: nothing is read from an entry before it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tdma_net_iface.sv
// Network interface between a Nios send/recv PIO pair and a shared TDMA bus.
// Define TDMA_NET_IFACE_STATS_EN to add the saturating drop_count output.
module tdma_net_iface
    import tdma_net_pkg::*;
#(
    parameter int NODE_ID     = 0,
    parameter int NODES       = 4,
    parameter int SLOT_CYCLES = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      send_word,
    output logic [31:0]      recv_word,
    input  logic             tdm_sync,
    output logic             noc_tx_valid,
    output logic [PKT_W-1:0] noc_tx_data,
    input  logic             noc_rx_valid,
    input  logic [PKT_W-1:0] noc_rx_data
`ifdef TDMA_NET_IFACE_STATS_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    localparam int CNT_W  = $clog2(SLOT_CYCLES);
    localparam int SLOT_W = $clog2(NODES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NODES - 1);
    localparam logic [SLOT_W-1:0] OWN_SLOT  = SLOT_W'(NODE_ID);
    localparam logic [NODE_W-1:0] OWN_ADDR  = NODE_W'(NODE_ID);

    logic [CNT_W-1:0]  cnt;
    logic [SLOT_W-1:0] slot;
    logic              tx_q;
    logic              ack_q;
    pres_state_e       state;

    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [PKT_W-1:0]  tx_rdata;

    logic              rx_match;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [RX_W-1:0]   rx_rdata;

    // Frame timebase; tdm_sync realigns every node to slot 0, cycle 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            slot <= '0;
        end else if (tdm_sync) begin
            cnt  <= '0;
            slot <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A pending tx toggle simply waits while the FIFO is full, so no word is lost.
    assign tx_push = (send_word[TOG_BIT] != tx_q) && !tx_full;
    assign tx_pop  = (slot == OWN_SLOT) && (cnt == '0) && !tx_empty;

    tdma_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .wdata   (make_pkt(send_word[DEST_MSB:DEST_LSB], OWN_ADDR,
                           send_word[PAYLOAD_W-1:0])),
        .pop     (tx_pop),
        .rdata   (tx_rdata),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q         <= 1'b0;
            noc_tx_valid <= 1'b0;
            noc_tx_data  <= '0;
        end else begin
            if (tx_push) begin
                tx_q <= send_word[TOG_BIT];
            end
            noc_tx_valid <= tx_pop;
            noc_tx_data  <= tx_pop ? tx_rdata : '0;
        end
    end

    // The dest field is implied by the filter, so only {src, payload} is stored.
    assign rx_match = noc_rx_valid && (noc_rx_data[PKT_W-1 -: NODE_W] == OWN_ADDR);
    assign rx_push  = rx_match && !rx_full;
    assign rx_pop   = (state == IDLE) && !rx_empty;

    tdma_sync_fifo #(
        .WIDTH (RX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .wdata   (noc_rx_data[RX_W-1:0]),
        .pop     (rx_pop),
        .rdata   (rx_rdata),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            recv_word <= '0;
            ack_q     <= 1'b0;
            state     <= IDLE;
        end else begin
            recv_word[FULL_BIT] <= tx_full;
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        recv_word[TOG_BIT]    <= ~recv_word[TOG_BIT];
                        recv_word[DEST_MSB:0] <= rx_rdata;
                        state                 <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (send_word[ACK_BIT] != ack_q) begin
                        ack_q <= send_word[ACK_BIT];
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TDMA_NET_IFACE_STATS_EN
    logic rx_drop;

    assign rx_drop = rx_match && rx_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (rx_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tdma_net_iface.sv
// Bench for tdma_net_iface: directed scenarios plus random traffic, checked
// against a queue-based frame-time model through an expected-response scoreboard.
module tb_tdma_net_iface;

    localparam int NODE_ID = 1;
    localparam int NODES   = 4;
    localparam int SC      = 8;
    localparam int DEPTH   = 4;

    logic        clk;
    logic        reset_n;
    logic [31:0] send_word;
    logic [31:0] recv_word;
    logic        tdm_sync;
    logic        noc_tx_valid;
    logic [33:0] noc_tx_data;
    logic        noc_rx_valid;
    logic [33:0] noc_rx_data;
`ifdef TDMA_NET_IFACE_STATS_EN
    logic [15:0] drop_count;
`endif

    tdma_net_iface #(
        .NODE_ID     (NODE_ID),
        .NODES       (NODES),
        .SLOT_CYCLES (SC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .send_word    (send_word),
        .recv_word    (recv_word),
        .tdm_sync     (tdm_sync),
        .noc_tx_valid (noc_tx_valid),
        .noc_tx_data  (noc_tx_data),
        .noc_rx_valid (noc_rx_valid),
        .noc_rx_data  (noc_rx_data)
`ifdef TDMA_NET_IFACE_STATS_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_check(input string name);
        n_checks++;
        $display("FAIL %s: expected event did not happen (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Time since the last reset/sync gives slot and cycle directly; FIFOs are queues.
    int          m_t;
    logic        m_tx_tog, m_wait, m_ack, m_rtog, m_full_r, m_fire;
    logic [29:0] m_last;
    logic [31:0] m_recv;
    int          m_drops;
    logic [33:0] m_txf[$];
    logic [29:0] m_rxf[$];
    logic [33:0] exp_tx_q[$];
    logic [30:0] exp_pres_q[$];

    task automatic model_reset();
        m_t = 0;
        m_tx_tog = 0; m_wait = 0; m_ack = 0; m_rtog = 0; m_full_r = 0; m_fire = 0;
        m_last = '0; m_recv = '0; m_drops = 0;
        m_txf.delete(); m_rxf.delete();
        exp_tx_q.delete(); exp_pres_q.delete();
    endtask

    task automatic model_step();
        int   pre_tx;
        int   pre_rx;
        logic full;
        pre_tx = m_txf.size();
        pre_rx = m_rxf.size();
        full = (pre_tx == DEPTH);
        m_full_r = full;
        m_fire = 0;
        if (((m_t / SC) % NODES) == NODE_ID && (m_t % SC) == 0 && pre_tx > 0) begin
            exp_tx_q.push_back(m_txf.pop_front());
            m_fire = 1;
        end
        if (send_word[31] != m_tx_tog && !full) begin
            m_txf.push_back({send_word[29:26], 4'(NODE_ID), send_word[25:0]});
            m_tx_tog = send_word[31];
        end
        if (m_wait) begin
            if (send_word[30] != m_ack) begin
                m_ack = send_word[30];
                m_wait = 0;
            end
        end else if (pre_rx > 0) begin
            m_last = m_rxf.pop_front();
            m_rtog = ~m_rtog;
            m_wait = 1;
            exp_pres_q.push_back({m_rtog, m_last});
        end
        if (noc_rx_valid && noc_rx_data[33:30] == 4'(NODE_ID)) begin
            if (pre_rx == DEPTH) begin
                if (m_drops < 65535) m_drops++;
            end else begin
                m_rxf.push_back(noc_rx_data[29:0]);
            end
        end
        m_t = tdm_sync ? 0 : m_t + 1;
        m_recv = {m_rtog, m_full_r, m_last};
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        prev_tog;
        logic [30:0] e;
        prev_tog = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                check("rst_recv_word", recv_word, 0);
                check("rst_tx_valid", noc_tx_valid, 0);
                check("rst_tx_data", noc_tx_data, 0);
                prev_tog = 0;
            end else begin
                check("cnt", dut.cnt, m_t % SC);
                check("slot", dut.slot, (m_t / SC) % NODES);
                check("tx_valid", noc_tx_valid, m_fire);
                if (noc_tx_valid && exp_tx_q.size() > 0) check("tx_data", noc_tx_data, exp_tx_q.pop_front());
                else if (!noc_tx_valid) check("tx_data_idle", noc_tx_data, 0);
                check("recv_word", recv_word, m_recv);
                if (recv_word[31] != prev_tog) begin
                    prev_tog = recv_word[31];
                    if (exp_pres_q.size() > 0) begin
                        e = exp_pres_q.pop_front();
                        check("present", {recv_word[31], recv_word[29:0]}, e);
                    end else begin
                        fail_check("present_unexpected");
                    end
                end
`ifdef TDMA_NET_IFACE_STATS_EN
                check("drop_count", drop_count, m_drops);
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_tx(input logic [3:0] dest, input logic [25:0] pl);
        int n;
        n = 0;
        while (m_tx_tog != send_word[31] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_check("send_tx_capture_timeout");
        send_word[31]   = ~send_word[31];
        send_word[29:0] = {dest, pl};
    endtask

    task automatic rx_inject(input logic [3:0] dest, input logic [3:0] src, input logic [25:0] pl);
        noc_rx_valid = 1'b1;
        noc_rx_data  = {dest, src, pl};
        @(negedge clk);
        noc_rx_valid = 1'b0;
        noc_rx_data  = '0;
    endtask

    task automatic do_ack();
        send_word[30] = ~send_word[30];
        @(negedge clk);
    endtask

    task automatic pulse_sync();
        tdm_sync = 1'b1;
        @(negedge clk);
        tdm_sync = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic found;
        reset_n      = 1'b0;
        send_word    = '0;
        tdm_sync     = 1'b0;
        noc_rx_valid = 1'b0;
        noc_rx_data  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word: one pulse in our slot with {dest, src, payload}
        send_tx(4'h2, 26'h0ABCDE);
        found = 0;
        for (int i = 0; i < NODES * SC + 4 && !found; i++) begin
            @(negedge clk);
            if (noc_tx_valid) begin
                found = 1;
                check("t1_pkt", noc_tx_data, {4'h2, 4'h1, 26'h0ABCDE});
            end
        end
        if (!found) fail_check("t1_no_pulse");

        // Five words from slot 0: full after four, fifth waits for the first launch
        pulse_sync();
        for (int i = 0; i < 5; i++) send_tx(4'(i), 26'(32'h100 + i));
        @(negedge clk);
        check("t2_tx_full", recv_word[30], 1'b1);
        repeat (5 * NODES * SC + 10) @(negedge clk);

        // Only packets addressed to this node are presented
        rx_inject(4'h1, 4'h3, 26'h1);
        rx_inject(4'h3, 4'h2, 26'h5);
        repeat (2) @(negedge clk);
        check("t3_recv_data", recv_word[29:0], {4'h3, 26'h1});
        check("t3_recv_tog", recv_word[31], 1'b1);
        do_ack();
        repeat (2) @(negedge clk);

        // Six packets with no ack: one presented, four queued, one dropped
        for (int i = 0; i < 6; i++) rx_inject(4'h1, 4'(i), 26'(16 + i));
        repeat (2) @(negedge clk);
        check("t4_first", recv_word[25:0], 26'd16);
`ifdef TDMA_NET_IFACE_STATS_EN
        check("t4_drop_count", drop_count, 16'd1);
`endif
        for (int k = 1; k <= 4; k++) begin
            do_ack();
            repeat (2) @(negedge clk);
            check("t4_next", recv_word[25:0], 26'(16 + k));
        end

        // tdm_sync at cnt 5, slot 2
        for (int i = 0; i < 2 * NODES * SC && !((m_t % SC) == 5 && ((m_t / SC) % NODES) == 2); i++)
            @(negedge clk);
        if ((m_t % SC) == 5 && ((m_t / SC) % NODES) == 2) begin
            pulse_sync();
            check("t5_cnt", dut.cnt, 0);
            check("t5_slot", dut.slot, 0);
        end else begin
            fail_check("t5_reach_slot2_cnt5");
        end

        // Reset while waiting for ack with packets queued
        rx_inject(4'h1, 4'h7, 26'h2A);
        rx_inject(4'h1, 4'h7, 26'h2B);
        send_tx(4'h0, 26'h3C);
        send_tx(4'h0, 26'h3D);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_recv_word", recv_word, 0);
        check("t6_tx_valid", noc_tx_valid, 0);
        check("t6_tx_empty", dut.tx_empty, 1);
        check("t6_rx_empty", dut.rx_empty, 1);
        send_word = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Random traffic
        repeat (800) begin
            @(negedge clk);
            if (m_tx_tog == send_word[31] && $urandom_range(0, 3) == 0) begin
                send_word[31]   = ~send_word[31];
                send_word[29:0] = 30'($urandom);
            end
            noc_rx_valid = ($urandom_range(0, 2) == 0);
            noc_rx_data  = {4'($urandom_range(0, 3)), 30'($urandom)};
            if (m_wait && send_word[30] == m_ack && $urandom_range(0, 2) == 0)
                send_word[30] = ~send_word[30];
            tdm_sync = ($urandom_range(0, 149) == 0);
        end

        // Drain: ack everything, let every queued word launch
        noc_rx_valid = 1'b0;
        noc_rx_data  = '0;
        tdm_sync     = 1'b0;
        repeat (240) begin
            @(negedge clk);
            if (m_wait && send_word[30] == m_ack) send_word[30] = ~send_word[30];
        end
        check("final_tx_empty", dut.tx_empty, 1);
        check("final_rx_empty", dut.rx_empty, 1);
        check("final_pres_pending", exp_pres_q.size(), 0);
        check("final_tx_pending", exp_tx_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
